switch_ingress_queue: RTL and testbench

SWITCH_INGRESS_QUEUE -- requirements
Module: switch_ingress_queue

---
 rtl/switch_ingress_queue.sv | 126 ++++++++++++
 tb/tb_switch_ingress_queue.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/switch_ingress_queue.sv
// Ingress FIFO feeding one switch port: filters self-loop/empty-target packets, first-word-fall-through head.
// Optional macro SWITCH_INGRESS_DROP_CNT_EN adds a saturating drop_cnt output.
module switch_ingress_queue #(
  parameter int PORT_ID = 0,
  parameter int DEPTH   = 4,
  localparam int PW     = $clog2(DEPTH),
  localparam int CW     = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [1:0]    in_source,
  input  logic [3:0]    in_target,
  input  logic [7:0]    in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [1:0]    out_source,
  output logic [3:0]    out_target,
  output logic [7:0]    out_data,
`ifdef SWITCH_INGRESS_DROP_CNT_EN
  output logic [7:0]    drop_cnt,
`endif
  output logic [CW-1:0] count
);

  localparam logic [1:0]    PORT_IDX  = PORT_ID[1:0];
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR  = PW'(DEPTH - 1);

  logic [13:0]   mem_r [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;

  logic          in_ready_s;
  logic          drop_s;
  logic          store_s;
  logic          pop_s;
  logic          not_empty_s;
  logic [PW-1:0] wr_ptr_nxt_s;
  logic [PW-1:0] rd_ptr_nxt_s;
  logic [CW-1:0] count_nxt_s;
  logic [13:0]   head_s;

  // Handshake decode, drop filter and next-state for pointers and occupancy
  always_comb begin
    not_empty_s  = (count_r != {CW{1'b0}});
    in_ready_s   = !rst && (count_r != FULL_CNT);
    drop_s       = (in_target == 4'b0000) || in_target[PORT_IDX];
    store_s      = in_valid && in_ready_s && !drop_s;
    pop_s        = not_empty_s && out_ready;
    wr_ptr_nxt_s = wr_ptr_r;
    rd_ptr_nxt_s = rd_ptr_r;
    count_nxt_s  = count_r;
    if (store_s) begin
      wr_ptr_nxt_s = (wr_ptr_r == LAST_PTR) ? {PW{1'b0}} : wr_ptr_r + PW'(1);
    end else begin
      wr_ptr_nxt_s = wr_ptr_r;
    end
    if (pop_s) begin
      rd_ptr_nxt_s = (rd_ptr_r == LAST_PTR) ? {PW{1'b0}} : rd_ptr_r + PW'(1);
    end else begin
      rd_ptr_nxt_s = rd_ptr_r;
    end
    case ({store_s, pop_s})
      2'b10:   count_nxt_s = count_r + CW'(1);
      2'b01:   count_nxt_s = count_r - CW'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      wr_ptr_r <= wr_ptr_nxt_s;
      rd_ptr_r <= rd_ptr_nxt_s;
      count_r  <= count_nxt_s;
    end
  end

  // Packet storage; contents need no reset because the head is masked when empty
  always_ff @(posedge clk) begin
    if (store_s) begin
      mem_r[wr_ptr_r] <= {in_source, in_target, in_data};
    end
  end

  // Head presentation, forced to zero while the queue is empty
  always_comb begin
    if (not_empty_s) begin
      head_s = mem_r[rd_ptr_r];
    end else begin
      head_s = 14'h0000;
    end
  end

  assign in_ready   = in_ready_s;
  assign out_valid  = not_empty_s;
  assign out_source = head_s[13:12];
  assign out_target = head_s[11:8];
  assign out_data   = head_s[7:0];
  assign count      = count_r;

`ifdef SWITCH_INGRESS_DROP_CNT_EN
  logic [7:0] drop_cnt_r;

  // Saturating count of accepted-but-filtered packets
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt_r <= 8'h00;
    end else if (in_valid && in_ready_s && drop_s && (drop_cnt_r != 8'hFF)) begin
      drop_cnt_r <= drop_cnt_r + 8'h01;
    end else begin
      drop_cnt_r <= drop_cnt_r;
    end
  end

  assign drop_cnt = drop_cnt_r;
`endif

endmodule

// File: tb/tb_switch_ingress_queue.sv
// Self-checking bench for switch_ingress_queue (PORT_ID=0, DEPTH=4): vector table plus scoreboard.
module tb_switch_ingress_queue;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_source;
  logic [3:0] in_target;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_source;
  logic [3:0] out_target;
  logic [7:0] out_data;
  logic [2:0] count;
`ifdef SWITCH_INGRESS_DROP_CNT_EN
  logic [7:0] drop_cnt;
`endif

  switch_ingress_queue #(.PORT_ID(0), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_source(in_source), .in_target(in_target), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_source(out_source), .out_target(out_target), .out_data(out_data),
`ifdef SWITCH_INGRESS_DROP_CNT_EN
    .drop_cnt(drop_cnt),
`endif
    .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [1:0] src;
    logic [3:0] tgt;
    logic [7:0] data;
    logic       ordy;
    logic       exp_drop;
  } vec_t;

  vec_t        vt [16];
  logic [13:0] sb [$];
  int          mdrop;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // One cycle: drive inputs, check outputs against the model at negedge, advance the model.
  task automatic drive(input logic v, input logic [1:0] src, input logic [3:0] tgt,
                       input logic [7:0] data, input logic ordy, input logic exp_drop);
    logic rdy, pop, push, dropped;
    in_valid  = v;
    in_source = src;
    in_target = tgt;
    in_data   = data;
    out_ready = ordy;
    @(negedge clk);
    chk("count", 32'(count), 32'(sb.size()));
    chk("in_ready", 32'(in_ready), 32'(sb.size() != 4));
    chk("out_valid", 32'(out_valid), 32'(sb.size() != 0));
    if (sb.size() != 0) chk("head", 32'({out_source, out_target, out_data}), 32'(sb[0]));
    else                chk("empty_head_zero", 32'({out_source, out_target, out_data}), 32'd0);
`ifdef SWITCH_INGRESS_DROP_CNT_EN
    chk("drop_cnt", 32'(drop_cnt), 32'(mdrop));
`endif
    rdy     = (sb.size() != 4);
    pop     = (sb.size() != 0) && ordy;
    push    = v && rdy && !exp_drop;
    dropped = v && rdy && exp_drop;
    if (pop) void'(sb.pop_front());
    if (push) sb.push_back({src, tgt, data});
    if (dropped && mdrop < 255) mdrop++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 2'd0, 4'b0000, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_head_zero", 32'({out_source, out_target, out_data}), 32'd0);
`ifdef SWITCH_INGRESS_DROP_CNT_EN
    chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    mdrop = 0;
  endtask

  initial begin
    vt[0]  = '{1'b1, 2'd1, 4'b0010, 8'h11, 1'b0, 1'b0};
    vt[1]  = '{1'b1, 2'd2, 4'b0100, 8'h22, 1'b0, 1'b0};
    vt[2]  = '{1'b1, 2'd3, 4'b0001, 8'h33, 1'b0, 1'b1};
    vt[3]  = '{1'b1, 2'd0, 4'b1000, 8'h44, 1'b1, 1'b0};
    vt[4]  = '{1'b1, 2'd1, 4'b0000, 8'h55, 1'b0, 1'b1};
    vt[5]  = '{1'b1, 2'd2, 4'b1110, 8'h66, 1'b0, 1'b0};
    vt[6]  = '{1'b1, 2'd3, 4'b1010, 8'h77, 1'b0, 1'b0};
    vt[7]  = '{1'b1, 2'd0, 4'b0110, 8'h88, 1'b0, 1'b0};
    vt[8]  = '{1'b1, 2'd1, 4'b1111, 8'h99, 1'b1, 1'b1};
    vt[9]  = '{1'b0, 2'd2, 4'b0100, 8'hA0, 1'b1, 1'b0};
    vt[10] = '{1'b1, 2'd2, 4'b1100, 8'hA1, 1'b1, 1'b0};
    vt[11] = '{1'b1, 2'd3, 4'b0011, 8'hA2, 1'b1, 1'b1};
    vt[12] = '{1'b1, 2'd0, 4'b0100, 8'hA3, 1'b0, 1'b0};
    vt[13] = '{1'b0, 2'd0, 4'b0000, 8'h00, 1'b1, 1'b0};
    vt[14] = '{1'b0, 2'd0, 4'b0000, 8'h00, 1'b1, 1'b0};
    vt[15] = '{1'b0, 2'd0, 4'b0000, 8'h00, 1'b1, 1'b0};

    in_source = 2'd0;
    in_target = 4'b0000;
    in_data   = 8'h00;
    do_reset();

    for (int i = 0; i < 16; i++)
      drive(vt[i].v, vt[i].src, vt[i].tgt, vt[i].data, vt[i].ordy, vt[i].exp_drop);
    idle(6);

    // Single packet: appears one cycle after accept for exactly one cycle
    do_reset();
    drive(1'b1, 2'd0, 4'b0010, 8'hAA, 1'b1, 1'b0);
    chk("single_visible", 32'(out_valid), 32'd1);
    chk("single_data", 32'(out_data), 32'hAA);
    chk("single_target", 32'(out_target), 32'b0010);
    idle(2);

    // Fill past full with out_ready low, then drain in order
    do_reset();
    for (int i = 1; i <= 5; i++) drive(1'b1, 2'd1, 4'b0010, 8'(i), 1'b0, 1'b0);
    chk("full_count", 32'(count), 32'd4);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    drive(1'b1, 2'd1, 4'b0010, 8'h05, 1'b1, 1'b0);
    drive(1'b1, 2'd1, 4'b0010, 8'h05, 1'b1, 1'b0);
    idle(6);

    // Self-loop and empty target dropped
    do_reset();
    drive(1'b1, 2'd2, 4'b0001, 8'hD1, 1'b1, 1'b1);
    drive(1'b1, 2'd2, 4'b0000, 8'hD2, 1'b1, 1'b1);
    idle(2);
    chk("drop_count_zero", 32'(count), 32'd0);
`ifdef SWITCH_INGRESS_DROP_CNT_EN
    chk("drop_cnt_two", 32'(drop_cnt), 32'd2);
`endif

    // Push+pop at count==1, then 10 packets streamed through the wrap
    do_reset();
    drive(1'b1, 2'd3, 4'b0100, 8'hB0, 1'b0, 1'b0);
    drive(1'b1, 2'd3, 4'b0100, 8'hBB, 1'b1, 1'b0);
    chk("pushpop_count", 32'(count), 32'd1);
    chk("pushpop_head", 32'(out_data), 32'hBB);
    for (int i = 0; i < 10; i++) drive(1'b1, 2'(i), 4'b1000, 8'(8'h40 + i), 1'b1, 1'b0);
    idle(3);

    // Push+pop at count==DEPTH-1
    for (int i = 0; i < 3; i++) drive(1'b1, 2'd1, 4'b0010, 8'(8'h60 + i), 1'b0, 1'b0);
    drive(1'b1, 2'd1, 4'b0010, 8'h63, 1'b1, 1'b0);
    chk("pushpop3_count", 32'(count), 32'd3);
    idle(5);

    // Mid-operation reset discards contents
    for (int i = 0; i < 3; i++) drive(1'b1, 2'd2, 4'b0100, 8'(8'h70 + i), 1'b0, 1'b0);
    do_reset();
    drive(1'b1, 2'd0, 4'b0010, 8'hCC, 1'b1, 1'b0);
    chk("post_rst_first", 32'(out_data), 32'hCC);
    idle(2);

    // 300 drops: counter saturates
    for (int i = 0; i < 300; i++) drive(1'b1, 2'd1, 4'b0001, 8'(i), 1'b1, 1'b1);
    idle(1);
    chk("sat_count_zero", 32'(count), 32'd0);
`ifdef SWITCH_INGRESS_DROP_CNT_EN
    chk("drop_cnt_sat", 32'(drop_cnt), 32'hFF);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
